sat_monitor: RTL and testbench

SAT_MONITOR -- requirements
Module: sat_monitor

---
 rtl/sat_pkg.sv | 23 ++
 rtl/sat_counter.sv | 26 ++
 rtl/sat_monitor.sv | 145 ++++++++++++++
 tb/tb_sat_monitor.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared definitions for the saturation filter / monitor family: FSM state
// encoding and the legal window for the alarm run length.
package sat_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OK    = 2'd1,
      ST_SAT   = 2'd2,
      ST_ALARM = 2'd3
   } sat_state_t;

   localparam int ALARM_LEN_MIN = 1;
   localparam int ALARM_LEN_MAX = 15;
   localparam int RUN_W         = 4;

   // Out-of-range run lengths are pulled back into the window the run counter can hold.
   function automatic int clamp_alarm_len(input int n);
      if (n < ALARM_LEN_MIN) return ALARM_LEN_MIN;
      if (n > ALARM_LEN_MAX) return ALARM_LEN_MAX;
      return n;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != {WIDTH{1'b1}})) begin
         r_cnt <= r_cnt + WIDTH'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/sat_monitor.sv
// Watches the saturation filter output: sustained-overflow alarm with
// hysteresis, sample/overflow statistics, peak hold and protocol checking.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | nothing accepted since reset/clear
// ST_OK    | last accepted sample was clean, no alarm
// ST_SAT   | overflow run in progress, r_run = run length so far
// ST_ALARM | alarm raised, r_run = consecutive clean samples seen
module sat_monitor
   import sat_pkg::*;
#(
   parameter int DATA_W    = 4,
   parameter int THRESHOLD = 8,
   parameter int ALARM_LEN = 3,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_ovf,
   output logic              alarm,
   output logic [CNT_W-1:0]  sample_cnt,
   output logic [CNT_W-1:0]  ovf_cnt,
   output logic [DATA_W-1:0] peak,
   output logic              proto_err
);

   localparam int                ALEN   = clamp_alarm_len(ALARM_LEN);
   localparam logic [RUN_W-1:0]  ALEN_R = RUN_W'(ALEN);
   localparam logic [DATA_W-1:0] THR    = DATA_W'(THRESHOLD);

   sat_state_t        r_state;
   sat_state_t        w_state_nxt;
   logic [RUN_W-1:0]  r_run;
   logic [RUN_W-1:0]  w_run_nxt;
   logic [RUN_W-1:0]  w_run_inc;
   logic              r_alarm;
   logic [DATA_W-1:0] r_peak;
   logic              r_perr;
   logic              w_accept;
   logic              w_viol;

   assign w_accept  = in_valid && !clr;
   assign w_run_inc = r_run + RUN_W'(1);

   // Overflow samples must sit exactly at threshold; idle cycles must be quiet.
   assign w_viol = in_valid ? (in_ovf ? (in_data != THR) : (in_data > THR))
                            : ((in_data != '0) || in_ovf);

   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run;
      if (w_accept) begin
         case (r_state)
            ST_IDLE, ST_OK: begin
               if (in_ovf) begin
                  if (ALEN == 1) begin
                     w_state_nxt = ST_ALARM;
                     w_run_nxt   = '0;
                  end else begin
                     w_state_nxt = ST_SAT;
                     w_run_nxt   = RUN_W'(1);
                  end
               end else begin
                  w_state_nxt = ST_OK;
                  w_run_nxt   = '0;
               end
            end
            ST_SAT: begin
               if (in_ovf) begin
                  if (w_run_inc == ALEN_R) begin
                     w_state_nxt = ST_ALARM;
                     w_run_nxt   = '0;
                  end else begin
                     w_run_nxt   = w_run_inc;
                  end
               end else begin
                  w_state_nxt = ST_OK;
                  w_run_nxt   = '0;
               end
            end
            ST_ALARM: begin
               if (in_ovf) begin
                  w_run_nxt = '0;
               end else if (w_run_inc == ALEN_R) begin
                  w_state_nxt = ST_OK;
                  w_run_nxt   = '0;
               end else begin
                  w_run_nxt   = w_run_inc;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_run_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_run   <= '0;
         r_alarm <= 1'b0;
         r_peak  <= '0;
         r_perr  <= 1'b0;
      end else if (clr) begin
         r_state <= ST_IDLE;
         r_run   <= '0;
         r_alarm <= 1'b0;
         r_peak  <= '0;
         r_perr  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= w_run_nxt;
         r_alarm <= (w_state_nxt == ST_ALARM);
         if (w_accept && (in_data > r_peak)) r_peak <= in_data;
         if (w_viol) r_perr <= 1'b1;
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_sample_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (clr),
      .i_en  (w_accept),
      .o_cnt (sample_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_ovf_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (clr),
      .i_en  (w_accept && in_ovf),
      .o_cnt (ovf_cnt)
   );

   assign alarm     = r_alarm;
   assign peak      = r_peak;
   assign proto_err = r_perr;

endmodule

// File: tb/tb_sat_monitor.sv
// Directed bench for sat_monitor (DATA_W=4, THRESHOLD=8, ALARM_LEN=3, CNT_W=4).
module tb_sat_monitor;
   import sat_pkg::*;

   localparam int DATA_W = 4;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clr;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ovf;
   logic              alarm;
   logic [CNT_W-1:0]  sample_cnt;
   logic [CNT_W-1:0]  ovf_cnt;
   logic [DATA_W-1:0] peak;
   logic              proto_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sat_monitor #(.DATA_W(DATA_W), .THRESHOLD(8), .ALARM_LEN(3), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ovf     (in_ovf),
      .alarm      (alarm),
      .sample_cnt (sample_cnt),
      .ovf_cnt    (ovf_cnt),
      .peak       (peak),
      .proto_err  (proto_err)
   );

   typedef struct {
      logic       c, v, o;
      logic [3:0] d;
      logic       e_alarm;
      logic [3:0] e_samp, e_ovf, e_peak;
      logic       e_perr;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic c, v, input logic [3:0] d, input logic o,
                               input logic ea, input logic [3:0] es, eo, ep,
                               input logic ee);
      vec_t r;
      r.c = c; r.v = v; r.d = d; r.o = o;
      r.e_alarm = ea; r.e_samp = es; r.e_ovf = eo; r.e_peak = ep; r.e_perr = ee;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input logic c, v, input logic [3:0] d, input logic o);
      @(negedge clk);
      clr = c; in_valid = v; in_data = d; in_ovf = o;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string nm, input logic ea, input logic [3:0] es, eo, ep,
                          input logic ee);
      chk({nm, " alarm"}, 32'(alarm), 32'(ea));
      chk({nm, " sample_cnt"}, 32'(sample_cnt), 32'(es));
      chk({nm, " ovf_cnt"}, 32'(ovf_cnt), 32'(eo));
      chk({nm, " peak"}, 32'(peak), 32'(ep));
      chk({nm, " proto_err"}, 32'(proto_err), 32'(ee));
   endtask

   initial begin
      // five clean samples of 3
      for (int i = 1; i <= 5; i++) vq.push_back(mk(0, 1, 3, 0, 0, 4'(i), 0, 3, 0));
      // overflow run with idle gaps: alarm after the third
      vq.push_back(mk(0, 1, 8, 1, 0, 6, 1, 8, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 6, 1, 8, 0));
      vq.push_back(mk(0, 1, 8, 1, 0, 7, 2, 8, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 7, 2, 8, 0));
      vq.push_back(mk(0, 1, 8, 1, 1, 8, 3, 8, 0));
      // hysteresis: clean,clean,ovf,clean,clean,clean
      vq.push_back(mk(0, 1, 3, 0, 1, 9, 3, 8, 0));
      vq.push_back(mk(0, 1, 3, 0, 1, 10, 3, 8, 0));
      vq.push_back(mk(0, 1, 8, 1, 1, 11, 4, 8, 0));
      vq.push_back(mk(0, 1, 3, 0, 1, 12, 4, 8, 0));
      vq.push_back(mk(0, 1, 3, 0, 1, 13, 4, 8, 0));
      vq.push_back(mk(0, 1, 3, 0, 0, 14, 4, 8, 0));
      // samples 15..20: counter saturates at 15
      vq.push_back(mk(0, 1, 3, 0, 0, 15, 4, 8, 0));
      for (int i = 0; i < 5; i++) vq.push_back(mk(0, 1, 3, 0, 0, 15, 4, 8, 0));
      // clr wins over a same-cycle valid overflow sample
      vq.push_back(mk(1, 1, 8, 1, 0, 0, 0, 0, 0));
      // overflow with off-threshold data: flagged, still counted, sticky
      vq.push_back(mk(0, 1, 5, 1, 0, 1, 1, 5, 1));
      for (int i = 2; i <= 11; i++) vq.push_back(mk(0, 1, 3, 0, 0, 4'(i), 1, 5, 1));
      vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      // clean sample exactly at threshold is legal, above is not
      vq.push_back(mk(0, 1, 8, 0, 0, 1, 0, 8, 0));
      vq.push_back(mk(0, 1, 9, 0, 0, 2, 0, 9, 1));
      vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      // idle-cycle violations: nonzero data, then ovf
      vq.push_back(mk(0, 0, 2, 0, 0, 0, 0, 0, 1));
      vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
      vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));

      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_ovf = 1'b0;
      #12;
      chk_all("reset", 0, 0, 0, 0, 0);
      chk("reset state", 32'(dut.r_state), 32'(ST_IDLE));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].c, vq[i].v, vq[i].d, vq[i].o);
         chk_all($sformatf("v%0d", i), vq[i].e_alarm, vq[i].e_samp, vq[i].e_ovf,
                 vq[i].e_peak, vq[i].e_perr);
         if (i == 4) chk("v4 state", 32'(dut.r_state), 32'(ST_OK));
      end
      chk("after clr state", 32'(dut.r_state), 32'(ST_IDLE));

      // async reset in the middle of an overflow run (run=2)
      step(0, 1, 8, 1);
      step(0, 1, 8, 1);
      chk_all("pre-rst", 0, 2, 2, 8, 0);
      chk("pre-rst state", 32'(dut.r_state), 32'(ST_SAT));
      step(0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk_all("async rst", 0, 0, 0, 0, 0);
      chk("async rst state", 32'(dut.r_state), 32'(ST_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 1, 8, 1);
      chk_all("post-rst 1", 0, 1, 1, 8, 0);
      chk("post-rst state", 32'(dut.r_state), 32'(ST_SAT));
      step(0, 1, 8, 1);
      chk_all("post-rst 2", 0, 2, 2, 8, 0);
      step(0, 1, 8, 1);
      chk_all("post-rst 3", 1, 3, 3, 8, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
